// File: rtl/nonce_scheduler_pkg.sv
// Shared definitions for the nonce scheduler and the SHA core boundary.
// Optional build macro: NONCE_SCHED_ABORT_EN (adds an abort input to the top).
package nonce_scheduler_pkg;

  localparam int NONCE_W              = 32;
  localparam int DEFAULT_CORE_LATENCY = 128;
  localparam int DEFAULT_ZERO_BITS    = 32;

  // Eight-word SHA-256 chaining state, word a in the most significant bits.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/nonce_scheduler_if.sv
// Host job / found-nonce handshakes plus the SHA core issue and result bus.
// Handshake rule for job_* and found_*: a transfer happens on a rising clock
// edge where valid and ready are both high; the offering side holds its
// payload stable while valid is high and ready is low.
interface nonce_scheduler_if;
  import nonce_scheduler_pkg::*;

  // host job channel
  logic               job_valid;
  logic               job_ready;
  HashState           job_mid;
  logic [31:0]        job_w1;
  logic [31:0]        job_w2;
  logic [NONCE_W-1:0] job_nonce_start;
  logic [NONCE_W-1:0] job_nonce_end;

  // core issue side
  logic               input_valid;
  logic               newblock_i;
  HashState           round1;
  logic [31:0]        w1;
  logic [31:0]        w2;
  logic [NONCE_W-1:0] w3;

  // core result side
  logic               output_valid;
  logic               newblock_o;
  HashState           doublehash;

  // golden nonce channel and status
  logic               found_valid;
  logic               found_ready;
  logic [NONCE_W-1:0] found_nonce;
  logic               found_overflow;
  logic               busy;
  logic               done;

  // scheduler side
  modport slave (
    input  job_valid, job_mid, job_w1, job_w2, job_nonce_start, job_nonce_end,
    input  output_valid, newblock_o, doublehash, found_ready,
    output job_ready, input_valid, newblock_i, round1, w1, w2, w3,
    output found_valid, found_nonce, found_overflow, busy, done
  );

  // host plus core side
  modport master (
    output job_valid, job_mid, job_w1, job_w2, job_nonce_start, job_nonce_end,
    output output_valid, newblock_o, doublehash, found_ready,
    input  job_ready, input_valid, newblock_i, round1, w1, w2, w3,
    input  found_valid, found_nonce, found_overflow, busy, done
  );

endinterface

// File: rtl/nonce_scheduler_delay_line.sv
// {valid, nonce} shift register mirroring the core pipeline so each core
// result can be paired with the nonce that produced it. DEPTH must be >= 2.
module nonce_delay_line #(
  parameter int DEPTH = 128,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_nonce,
  output logic         head_valid,
  output logic [W-1:0] head_nonce,
  output logic         body_empty
);

  logic [DEPTH-1:0] v_q;
  logic [W-1:0]     n_q [DEPTH];

  // Shift one stage per cycle; stage DEPTH-1 lines up with the core output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) n_q[i] <= '0;
    end else begin
      v_q    <= {v_q[DEPTH-2:0], in_valid};
      n_q[0] <= in_nonce;
      for (int i = 1; i < DEPTH; i++) n_q[i] <= n_q[i-1];
    end
  end

  assign head_valid = v_q[DEPTH-1];
  assign head_nonce = n_q[DEPTH-1];
  // Nothing behind the head: once the head is checked, the line is empty.
  assign body_empty = ~|v_q[DEPTH-2:0];

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: takes one mining job, issues one nonce per cycle to the
// SHA core, pairs each result with its nonce and reports golden nonces.
// Optional build macro: NONCE_SCHED_ABORT_EN adds an 'abort' input that ends
// the issue phase early; the job still drains and pulses done.
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
  parameter int ZERO_BITS    = DEFAULT_ZERO_BITS
) (
  input  logic         clk,
  input  logic         rst,
`ifdef NONCE_SCHED_ABORT_EN
  input  logic         abort,
`endif
  nonce_scheduler_if.slave bus,
  output sched_state_t dbg_state
);

  sched_state_t       state;
  logic               job_ready_q;
  logic               input_valid_q;
  logic               newblock_q;
  HashState           round1_q;
  logic [31:0]        w1_q;
  logic [31:0]        w2_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] nonce_end_q;
  logic               busy_q;
  logic               done_q;

  logic               found_valid_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic               found_overflow_q;

  logic               head_valid;
  logic [NONCE_W-1:0] head_nonce;
  logic               body_empty;
  logic               stop_req;
  logic               hit;

`ifdef NONCE_SCHED_ABORT_EN
  assign stop_req = abort;
`else
  assign stop_req = 1'b0;
`endif

  nonce_delay_line #(
    .DEPTH (CORE_LATENCY),
    .W     (NONCE_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (input_valid_q),
    .in_nonce   (nonce_q),
    .head_valid (head_valid),
    .head_nonce (head_nonce),
    .body_empty (body_empty)
  );

  // Job sequencer: IDLE accepts a job, ISSUE streams nonces, DRAIN waits for
  // the last in-flight result before pulsing done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      job_ready_q   <= 1'b1;
      input_valid_q <= 1'b0;
      newblock_q    <= 1'b0;
      round1_q      <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      newblock_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.job_valid && job_ready_q) begin
            round1_q    <= bus.job_mid;
            w1_q        <= bus.job_w1;
            w2_q        <= bus.job_w2;
            nonce_end_q <= bus.job_nonce_end;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.job_nonce_start > bus.job_nonce_end) begin
              // empty range: nothing to issue, drain immediately
              state         <= DRAIN;
              input_valid_q <= 1'b0;
            end else begin
              state         <= ISSUE;
              input_valid_q <= 1'b1;
              newblock_q    <= 1'b1;
              nonce_q       <= bus.job_nonce_start;
            end
          end
        end
        ISSUE: begin
          // end is found by equality so a full 0..FFFFFFFF range never wraps
          if (stop_req || (nonce_q == nonce_end_q)) begin
            state         <= DRAIN;
            input_valid_q <= 1'b0;
          end else begin
            nonce_q       <= nonce_q + 1'b1;
            input_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          input_valid_q <= 1'b0;
          if (body_empty) begin
            state       <= IDLE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            job_ready_q <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          input_valid_q <= 1'b0;
          job_ready_q   <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  // A hit needs the top ZERO_BITS bits of the final word to be zero.
  assign hit = bus.output_valid &&
               (bus.doublehash.h[31 -: ZERO_BITS] == '0);

  // Golden-nonce holding register with sticky overflow for dropped hits and
  // for core results that disagree with the delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_valid_q    <= 1'b0;
      found_nonce_q    <= '0;
      found_overflow_q <= 1'b0;
    end else begin
      if (hit) begin
        if (!found_valid_q || bus.found_ready) begin
          found_valid_q <= 1'b1;
          found_nonce_q <= head_nonce;
        end else begin
          found_overflow_q <= 1'b1;
        end
      end else if (found_valid_q && bus.found_ready) begin
        found_valid_q <= 1'b0;
      end
      if (bus.output_valid != head_valid) found_overflow_q <= 1'b1;
    end
  end

  // newblock_o and the lower hash words are not needed for screening.
  logic unused_core;
  assign unused_core = ^{bus.newblock_o, bus.doublehash};

  assign bus.job_ready      = job_ready_q;
  assign bus.input_valid    = input_valid_q;
  assign bus.newblock_i     = newblock_q;
  assign bus.round1         = round1_q;
  assign bus.w1             = w1_q;
  assign bus.w2             = w2_q;
  assign bus.w3             = nonce_q;
  assign bus.found_valid    = found_valid_q;
  assign bus.found_nonce    = found_nonce_q;
  assign bus.found_overflow = found_overflow_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency core model.
module tb_nonce_scheduler;
  import nonce_scheduler_pkg::*;

  localparam int L = 128;

  logic clk;
  logic rst;
  sched_state_t dbg_state;
`ifdef NONCE_SCHED_ABORT_EN
  logic abort;
`endif

  nonce_scheduler_if bus ();

  nonce_scheduler #(
    .CORE_LATENCY (L),
    .ZERO_BITS    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NONCE_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic        cm_v  [L];
  logic        cm_nb [L];
  logic [31:0] cm_n  [L];
  logic [31:0] hit_a, hit_b;
  logic        hit_a_en, hit_b_en;
  logic [31:0] cm_h;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        cm_v[i] <= 1'b0; cm_nb[i] <= 1'b0; cm_n[i] <= '0;
      end
    end else begin
      cm_v[0] <= bus.input_valid; cm_nb[0] <= bus.newblock_i; cm_n[0] <= bus.w3;
      for (int i = 1; i < L; i++) begin
        cm_v[i] <= cm_v[i-1]; cm_nb[i] <= cm_nb[i-1]; cm_n[i] <= cm_n[i-1];
      end
    end
  end

  assign cm_h = ((hit_a_en && cm_n[L-1] == hit_a) || (hit_b_en && cm_n[L-1] == hit_b))
                ? 32'h0 : 32'hDEAD_BEEF;
  assign bus.output_valid = cm_v[L-1];
  assign bus.newblock_o   = cm_nb[L-1];
  assign bus.doublehash   = {cm_n[L-1], 192'h0, cm_h};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  HashState    mid;
  logic [31:0] w1v, w2v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // record every consumed golden nonce
  always @(negedge clk) begin
    if (rst && bus.found_valid && bus.found_ready) got_q.push_back(bus.found_nonce);
  end

  // ---------------- driver ----------------
  // Offer one job and follow it to done. Cycle 0 is the first cycle after the
  // accepting edge; done is expected exp_done cycles later.
  task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] e,
                         input int abort_at, input int exp_n, input int exp_done);
    int n, done_at, done_cnt;
    n = 0; done_at = -1; done_cnt = 0;
    @(negedge clk);
    chk({tag, "_ready"}, 64'(bus.job_ready), 64'd1);
    bus.job_valid = 1'b1; bus.job_mid = mid; bus.job_w1 = w1v; bus.job_w2 = w2v;
    bus.job_nonce_start = s; bus.job_nonce_end = e;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    for (int cyc = 0; cyc < exp_n + L + 20; cyc++) begin
      @(negedge clk);
`ifdef NONCE_SCHED_ABORT_EN
      abort = (cyc == abort_at);
`endif
      if (bus.input_valid) begin
        chk({tag, "_w3"}, 64'(bus.w3), 64'(s + n));
        chk({tag, "_newblock"}, 64'(bus.newblock_i), 64'(n == 0));
        chk({tag, "_round1"}, 64'(bus.round1 == mid), 64'd1);
        chk({tag, "_w1w2"}, {bus.w1, bus.w2}, {w1v, w2v});
        n++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
`ifdef NONCE_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    chk({tag, "_issued"}, 64'(n), 64'(exp_n));
    chk({tag, "_done_at"}, 64'(done_at), 64'(exp_done));
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
    chk({tag, "_input_valid"}, 64'(bus.input_valid), 64'd0);
    chk({tag, "_newblock"}, 64'(bus.newblock_i), 64'd0);
    chk({tag, "_found_valid"}, 64'(bus.found_valid), 64'd0);
    chk({tag, "_overflow"}, 64'(bus.found_overflow), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_found_nonce"}, 64'(bus.found_nonce), 64'd0);
    chk({tag, "_w3"}, 64'(bus.w3), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0;
    bus.job_valid = 1'b0; bus.job_mid = '0; bus.job_w1 = '0; bus.job_w2 = '0;
    bus.job_nonce_start = '0; bus.job_nonce_end = '0; bus.found_ready = 1'b0;
`ifdef NONCE_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    hit_a = '0; hit_b = '0; hit_a_en = 1'b0; hit_b_en = 1'b0;
    mid = '0; w1v = 32'h1111_2222; w2v = 32'h3333_4444;
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("post_rst");

    // basic 4-nonce job
    run_job("basic", 32'h100, 32'h103, -1, 4, 4 + L);
    chk("basic_found", 64'(bus.found_valid), 64'd0);

    // golden nonce 0x1234 in 0x1230..0x1237
    mid = '{a:32'h9524c593, b:32'h05c56713, c:32'h16e669ba, d:32'h2d2810a0,
            e:32'h07e86e37, f:32'h2f56a9da, g:32'hcd5bce69, h:32'h7a78da2d};
    w1v = 32'hf1fc122b; w2v = 32'hc7f5d74d;
    hit_a = 32'h1234; hit_a_en = 1'b1;
    run_job("gold", 32'h1230, 32'h1237, -1, 8, 8 + L);
    chk("gold_valid", 64'(bus.found_valid), 64'd1);
    chk("gold_nonce", 64'(bus.found_nonce), 64'h1234);
    chk("gold_overflow", 64'(bus.found_overflow), 64'd0);
    @(negedge clk) bus.found_ready = 1'b1;
    @(negedge clk) bus.found_ready = 1'b0;
    chk("gold_cleared", 64'(bus.found_valid), 64'd0);
    chk("gold_consumed", 64'(got_q.size()), 64'd1);
    got_q.delete();

    // back-to-back hits 5,6 with the host always ready
    hit_a = 32'd5; hit_b = 32'd6; hit_b_en = 1'b1;
    bus.found_ready = 1'b1;
    run_job("pair_rdy", 32'd0, 32'd9, -1, 10, 10 + L);
    bus.found_ready = 1'b0;
    exp_q.delete(); exp_q.push_back(32'd5); exp_q.push_back(32'd6);
    chk("pair_rdy_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("pair_rdy_nonce", 64'(got_q[i]), 64'(exp_q[i]));
    chk("pair_rdy_overflow", 64'(bus.found_overflow), 64'd0);
    chk("pair_rdy_valid", 64'(bus.found_valid), 64'd0);
    got_q.delete();

    // same hits with the host stalled: second one is dropped
    run_job("pair_stall", 32'd0, 32'd9, -1, 10, 10 + L);
    chk("pair_stall_valid", 64'(bus.found_valid), 64'd1);
    chk("pair_stall_nonce", 64'(bus.found_nonce), 64'd5);
    chk("pair_stall_overflow", 64'(bus.found_overflow), 64'd1);
    hit_a_en = 1'b0; hit_b_en = 1'b0;

    // empty range
    run_job("empty", 32'h10, 32'h0F, -1, 0, 1);
    chk("empty_overflow_sticky", 64'(bus.found_overflow), 64'd1);

    // asynchronous reset in the middle of issue
    @(negedge clk);
    bus.job_valid = 1'b1; bus.job_nonce_start = 32'h0; bus.job_nonce_end = 32'h3F;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 chk("mid_issue_valid", 64'(bus.input_valid), 64'd1);
    rst = 1'b0;
    #1 chk_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_job("clean", 32'h20, 32'h21, -1, 2, 2 + L);
    chk("clean_found", 64'(bus.found_valid), 64'd0);
    chk("clean_overflow", 64'(bus.found_overflow), 64'd0);

`ifdef NONCE_SCHED_ABORT_EN
    run_job("abort", 32'd0, 32'd99, 2, 3, 3 + L);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
